aes_uart_sequencer: RTL and testbench
=====================================

AES_UART_SEQUENCER -- requirements
Module: aes_uart_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max cycles to wait for aes_done before error.
REQ-002 SHALL have parameter IDLE_ACK, default 8'h06, meaning byte sent after a key or seed load completes.
REQ-003 io_clk  input  1  sole clock; all logic on rising edge.
REQ-004 io_reset_n  input  1  asynchronous, active-low reset.
REQ-005 rx_valid  input  1  received UART byte valid.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 rx_ready  output  1  sequencer accepts rx_data this cycle.
REQ-008 tx_valid  output  1  byte to UART transmitter valid.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 tx_ready  input  1  transmitter accepts tx_data this cycle.
REQ-011 aes_key  output  128  key to masked AES core.
REQ-012 aes_pt  output  128  plaintext to masked AES core.
REQ-013 aes_start  output  1  one-cycle start pulse to core.
REQ-014 aes_done  input  1  one-cycle completion pulse from core.
REQ-015 aes_ct  input  128  ciphertext, valid in aes_done cycle.
REQ-016 io_done  output  1  level: ciphertext fully transmitted.

Function
REQ-017 States SHALL be IDLE, RX_KEY, RX_PT, RX_SEED, START, WAIT, TX_CT, TX_BYTE.
REQ-018 Transfer SHALL occur on valid&&ready; tx_data and tx_valid SHALL stay stable until tx_ready.
REQ-019 rx_ready SHALL be 1 only in IDLE, RX_KEY, RX_PT, RX_SEED.
REQ-020 IDLE: byte 8'h4B ('K') -> RX_KEY; 8'h50 ('P') -> RX_PT and io_done cleared; any other byte -> TX_BYTE with 8'h3F ('?').
REQ-021 RX_KEY/RX_PT SHALL accept exactly 16 bytes via a 4-bit counter; first byte lands in bits [127:120], last in [7:0].
REQ-022 After 16th key byte: aes_key updated atomically, then TX_BYTE with IDLE_ACK; aes_key SHALL not change while partial.
REQ-023 After 16th plaintext byte: aes_pt updated, -> START.
REQ-024 START SHALL assert aes_start for exactly one cycle, then -> WAIT with timeout counter cleared.
REQ-025 WAIT: aes_done latches aes_ct into a 128-bit buffer, -> TX_CT; aes_done outside WAIT SHALL be ignored.
REQ-026 WAIT: counter reaching TIMEOUT_CYCLES-1 without aes_done -> TX_BYTE with 8'h45 ('E'); aes_done in that same cycle wins.
REQ-027 TX_CT SHALL send 16 bytes, [127:120] first; after last accepted byte io_done=1, -> IDLE.
REQ-028 TX_BYTE SHALL send one byte then -> IDLE.
REQ-029 Latency: aes_start SHALL rise the cycle after the 16th plaintext byte is accepted; first ciphertext tx_valid the cycle after aes_done.
REQ-030 Back-to-back 'P' commands SHALL reuse the last loaded key; key before any 'K' is all-zero.

Reset
REQ-031 Asserting io_reset_n low SHALL, at any time, force IDLE, counters 0, aes_key/aes_pt/ct buffer 0, rx_ready 1 after release, tx_valid 0, aes_start 0, io_done 0.
REQ-032 Reset mid-frame SHALL discard partial bytes; a late aes_done after reset SHALL be ignored.

Configuration
REQ-033 With MASK_RESEED_EN defined: IDLE byte 8'h53 ('S') -> RX_SEED, accepts 4 bytes (first in [31:24]), drives added outputs mask_seed (32, reset 0) and seed_load (1-cycle pulse), then TX_BYTE IDLE_ACK.
REQ-034 Without MASK_RESEED_EN: RX_SEED, mask_seed, seed_load absent; 'S' answered with 8'h3F.

Structure
REQ-035 Shared package aes_seq_pkg SHALL hold the state enum, command bytes 'K','P','S', reply bytes '?','E', and block width 128.
REQ-036 One sub-module aes_seq_shreg (16-byte load/unload shift register with byte counter) SHALL be used for RX key, RX plaintext and TX ciphertext.

Verification
REQ-037 'K' + 00..0F, 'P' + 00112233..FF, model core returns FIPS-197 ct -> one 8'h06, aes_start pulse, tx 69 C4 E0 D8 6A 7B 04 30 D8 CD B7 80 70 B4 C5 5A, io_done=1.
REQ-038 Byte 8'h41 in IDLE -> single tx 8'h3F, state IDLE, aes_key unchanged.
REQ-039 'P' + 16 bytes, core never pulses aes_done -> 8'h45 sent exactly TIMEOUT_CYCLES cycles after aes_start.
REQ-040 tx_ready held low 50 cycles during TX_CT -> tx_data constant, no byte lost or duplicated.
REQ-041 io_reset_n pulsed low after 7 key bytes, then 'P' + 16 bytes -> aes_key==0 at aes_start.
REQ-042 MASK_RESEED_EN: 'S' DE AD BE EF -> mask_seed==32'hDEADBEEF, one seed_load pulse, tx 8'h06; undefined -> tx 8'h3F.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the UART-driven AES sequencer.
package aes_seq_pkg;

  localparam int BLOCK_W     = 128;
  localparam int BLOCK_BYTES = BLOCK_W / 8;

  localparam logic [7:0] CMD_KEY     = 8'h4B;
  localparam logic [7:0] CMD_PT      = 8'h50;
  localparam logic [7:0] CMD_SEED    = 8'h53;
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
  localparam logic [7:0] RSP_TIMEOUT = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_KEY,
    ST_RX_PT,
    ST_RX_SEED,
    ST_START,
    ST_WAIT,
    ST_TX_CT,
    ST_TX_BYTE
  } state_t;

endpackage

// File: rtl/aes_seq_shreg.sv
// Byte-wide load/unload shift register with byte counter, shared by receive and transmit paths.
// Holds the 15 bytes not yet consumed: on receive the 16th byte completes 'word' directly,
// on transmit the first byte goes straight to the output register at load time.
module aes_seq_shreg
  import aes_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load,
  input  logic [BLOCK_W-9:0]   load_data,
  input  logic                 shift,
  input  logic [7:0]           shift_byte,
  output logic [BLOCK_W-1:0]   word,
  output logic [7:0]           next_byte,
  output logic [3:0]           cnt
);

  logic [BLOCK_W-9:0] data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (clr) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      data <= {data[BLOCK_W-17:0], shift_byte};
      cnt  <= cnt + 4'd1;
    end
  end

  assign word      = {data, shift_byte};
  assign next_byte = data[BLOCK_W-9 -: 8];

endmodule

// File: rtl/aes_uart_sequencer.sv
// UART command sequencer for a masked AES core: loads key/plaintext, runs the core, returns ciphertext.
// Optional mask reseed command ('S') is built when MASK_RESEED_EN is defined.
module aes_uart_sequencer
  import aes_seq_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter logic [7:0] IDLE_ACK       = 8'h06
) (
  input  logic               io_clk,
  input  logic               io_reset_n,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic [BLOCK_W-1:0] aes_key,
  output logic [BLOCK_W-1:0] aes_pt,
  output logic               aes_start,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_ct,
  output logic               io_done
`ifdef MASK_RESEED_EN
  , output logic [31:0]      mask_seed
  , output logic             seed_load
`endif
);

  localparam int             TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [TW-1:0]        tcnt;
  logic                 rx_fire;
  logic                 rx_clr;
  logic                 rx_shift;
  logic                 tx_load;
  logic                 tx_shift;
  logic [BLOCK_W-1:0]   rx_word;
  logic [3:0]           rx_cnt;
  logic [7:0]           tx_next;
  logic [3:0]           tx_cnt;

  assign rx_ready = (state == ST_IDLE) || (state == ST_RX_KEY) ||
                    (state == ST_RX_PT) || (state == ST_RX_SEED);
  assign rx_fire  = rx_valid && rx_ready;
  assign rx_clr   = rx_fire && (state == ST_IDLE);
  assign rx_shift = rx_fire && (state != ST_IDLE);
  assign tx_load  = (state == ST_WAIT) && aes_done;
  assign tx_shift = (state == ST_TX_CT) && tx_valid && tx_ready;

  aes_seq_shreg u_rx_shreg (
    .clk        (io_clk),
    .rst_n      (io_reset_n),
    .clr        (rx_clr),
    .load       (1'b0),
    .load_data  ('0),
    .shift      (rx_shift),
    .shift_byte (rx_data),
    .word       (rx_word),
    .next_byte  (),
    .cnt        (rx_cnt)
  );

  aes_seq_shreg u_tx_shreg (
    .clk        (io_clk),
    .rst_n      (io_reset_n),
    .clr        (1'b0),
    .load       (tx_load),
    .load_data  (aes_ct[BLOCK_W-9:0]),
    .shift      (tx_shift),
    .shift_byte (8'h00),
    .word       (),
    .next_byte  (tx_next),
    .cnt        (tx_cnt)
  );

  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      state     <= ST_IDLE;
      tcnt      <= '0;
      aes_key   <= '0;
      aes_pt    <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      aes_start <= 1'b0;
      io_done   <= 1'b0;
`ifdef MASK_RESEED_EN
      mask_seed <= '0;
      seed_load <= 1'b0;
`endif
    end else begin
      aes_start <= 1'b0;
`ifdef MASK_RESEED_EN
      seed_load <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_fire) begin
            case (rx_data)
              CMD_KEY: state <= ST_RX_KEY;
              CMD_PT: begin
                state   <= ST_RX_PT;
                io_done <= 1'b0;
              end
`ifdef MASK_RESEED_EN
              CMD_SEED: state <= ST_RX_SEED;
`endif
              default: begin
                state    <= ST_TX_BYTE;
                tx_valid <= 1'b1;
                tx_data  <= RSP_UNKNOWN;
              end
            endcase
          end
        end
        // Key and plaintext registers only change once the whole block has arrived.
        ST_RX_KEY: begin
          if (rx_fire && rx_cnt == 4'd15) begin
            aes_key  <= rx_word;
            state    <= ST_TX_BYTE;
            tx_valid <= 1'b1;
            tx_data  <= IDLE_ACK;
          end
        end
        ST_RX_PT: begin
          if (rx_fire && rx_cnt == 4'd15) begin
            aes_pt    <= rx_word;
            state     <= ST_START;
            aes_start <= 1'b1;
          end
        end
`ifdef MASK_RESEED_EN
        ST_RX_SEED: begin
          if (rx_fire && rx_cnt == 4'd3) begin
            mask_seed <= rx_word[31:0];
            seed_load <= 1'b1;
            state     <= ST_TX_BYTE;
            tx_valid  <= 1'b1;
            tx_data   <= IDLE_ACK;
          end
        end
`endif
        ST_START: begin
          state <= ST_WAIT;
          tcnt  <= '0;
        end
        // A completion arriving on the final timeout cycle still counts as success.
        ST_WAIT: begin
          if (aes_done) begin
            state    <= ST_TX_CT;
            tx_valid <= 1'b1;
            tx_data  <= aes_ct[BLOCK_W-1 -: 8];
          end else if (tcnt == TIMEOUT_LAST) begin
            state    <= ST_TX_BYTE;
            tx_valid <= 1'b1;
            tx_data  <= RSP_TIMEOUT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_TX_CT: begin
          if (tx_valid && tx_ready) begin
            if (tx_cnt == 4'd15) begin
              tx_valid <= 1'b0;
              io_done  <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              tx_data <= tx_next;
            end
          end
        end
        ST_TX_BYTE: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_uart_sequencer.sv
// Directed bench for aes_uart_sequencer with a transaction-level reply model and per-cycle compare.
// Covers the MASK_RESEED_EN build when that macro is defined.
module tb_aes_uart_sequencer;

  localparam int TO = 64;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2      = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT3      = 128'hfedcba98765432100123456789abcdef;
  localparam logic [127:0] KEY3     = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;

  logic         io_clk = 1'b0;
  logic         io_reset_n = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready = 1'b1;
  logic [127:0] aes_key;
  logic [127:0] aes_pt;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_ct = '0;
  logic         io_done;
`ifdef MASK_RESEED_EN
  logic [31:0]  mask_seed;
  logic         seed_load;
`endif

  aes_uart_sequencer #(.TIMEOUT_CYCLES(TO), .IDLE_ACK(8'h06)) dut (
    .io_clk     (io_clk),
    .io_reset_n (io_reset_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .aes_key    (aes_key),
    .aes_pt     (aes_pt),
    .aes_start  (aes_start),
    .aes_done   (aes_done),
    .aes_ct     (aes_ct),
    .io_done    (io_done)
`ifdef MASK_RESEED_EN
    , .mask_seed (mask_seed)
    , .seed_load (seed_load)
`endif
  );

  always #5 io_clk = ~io_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seed_pulses = 0;
  int cyc_start, cyc_tx, n0;
  bit seen;
  logic [7:0]   exp_q[$];
  logic [7:0]   log_q[$];
  logic [127:0] model_key = '0;
  logic [127:0] model_pt = '0;
  logic         prev_stall = 1'b0;
  logic         prev_start = 1'b0;
  logic [7:0]   prev_data = 8'h00;
  logic [7:0]   fips_bytes [16] = '{8'h69, 8'hC4, 8'hE0, 8'hD8, 8'h6A, 8'h7B, 8'h04, 8'h30,
                                    8'hD8, 8'hCD, 8'hB7, 8'h80, 8'h70, 8'hB4, 8'hC5, 8'h5A};

  always @(posedge io_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] last_log();
    if (log_q.size() == 0) return 8'hxx;
    return log_q[log_q.size()-1];
  endfunction

  // Per-cycle compare against the expected reply stream and the model's key/plaintext.
  always @(negedge io_clk) begin
    if (io_reset_n) begin
      if (prev_stall) begin
        check("tx_hold_valid", {127'b0, tx_valid}, 128'd1);
        check("tx_hold_data", {120'b0, tx_data}, {120'b0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected actual=%h required=none", tx_data);
        end else begin
          check("tx_byte", {120'b0, tx_data}, {120'b0, exp_q.pop_front()});
        end
        log_q.push_back(tx_data);
        $display("tx byte %h at cycle %0d", tx_data, cyc);
      end
      if (aes_start) begin
        check("start_key", aes_key, model_key);
        check("start_pt", aes_pt, model_pt);
        check("start_single", {127'b0, prev_start}, 128'd0);
      end
`ifdef MASK_RESEED_EN
      if (seed_load) seed_pulses++;
`endif
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_start = aes_start;
    end else begin
      prev_stall = 1'b0;
      prev_start = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 500; k++) begin
      @(negedge io_clk);
      if (rx_ready) begin
        @(posedge io_clk);
        #1;
        rx_valid = 1'b0;
        return;
      end
    end
    rx_valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL rx_accept_timeout actual=not_ready required=ready byte=%h", b);
  endtask

  task automatic send_data(input logic [127:0] val, input int first, input int count);
    for (int i = first; i < first + count; i++) send_byte(val[127-8*i -: 8]);
  endtask

  task automatic wait_idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge io_clk);
      #1;
      if (exp_q.size() == 0 && !tx_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
  endtask

  // Stand-in core: known-answer for the FIPS-197 vector, a fixed mixing otherwise.
  task automatic core_respond(input int lat);
    logic [127:0] ct;
    ct = (aes_key == FIPS_KEY && aes_pt == FIPS_PT) ? FIPS_CT
                                                    : (aes_key ^ {aes_pt[63:0], aes_pt[127:64]});
    repeat (lat) @(posedge io_clk);
    #1;
    aes_done = 1'b1;
    aes_ct   = ct;
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
    @(posedge io_clk);
    #1;
    aes_done = 1'b0;
    aes_ct   = '0;
    check("ct_latency_valid", {127'b0, tx_valid}, 128'd1);
    check("ct_first_byte", {120'b0, tx_data}, {120'b0, ct[127:120]});
  endtask

  task automatic do_reset();
    io_reset_n = 1'b0;
    repeat (3) @(posedge io_clk);
    #1;
    io_reset_n = 1'b1;
    exp_q.delete();
    model_key = '0;
    model_pt  = '0;
  endtask

  initial begin
    do_reset();
    check("rst_rx_ready", {127'b0, rx_ready}, 128'd1);
    check("rst_tx_valid", {127'b0, tx_valid}, 128'd0);
    check("rst_aes_start", {127'b0, aes_start}, 128'd0);
    check("rst_io_done", {127'b0, io_done}, 128'd0);
    check("rst_aes_key", aes_key, 128'd0);
    check("rst_aes_pt", aes_pt, 128'd0);

    // Unknown command before any key load
    log_q.delete();
    send_byte(8'h41);
    exp_q.push_back(8'h3F);
    wait_idle(50);
    check("unk_count", log_q.size(), 128'd1);
    check("unk_byte", {120'b0, last_log()}, 128'h3F);
    check("unk_idle", {127'b0, rx_ready}, 128'd1);
    check("unk_key", aes_key, 128'd0);

    // FIPS-197 known answer
    log_q.delete();
    send_byte(8'h4B);
    send_data(FIPS_KEY, 0, 16);
    model_key = FIPS_KEY;
    exp_q.push_back(8'h06);
    check("fips_key_loaded", aes_key, FIPS_KEY);
    wait_idle(50);
    send_byte(8'h50);
    send_data(FIPS_PT, 0, 16);
    model_pt = FIPS_PT;
    check("fips_start_latency", {127'b0, aes_start}, 128'd1);
    core_respond(3);
    wait_idle(100);
    check("fips_io_done", {127'b0, io_done}, 128'd1);
    check("fips_count", log_q.size(), 128'd17);
    if (log_q.size() == 17) begin
      check("fips_ack", {120'b0, log_q[0]}, 128'h06);
      for (int i = 0; i < 16; i++) check("fips_ct", {120'b0, log_q[i+1]}, {120'b0, fips_bytes[i]});
    end

    // Partial key must not disturb the live key; unknown byte leaves it alone
    send_byte(8'h4B);
    send_data(KEY2, 0, 8);
    check("key_partial", aes_key, FIPS_KEY);
    send_data(KEY2, 8, 8);
    model_key = KEY2;
    exp_q.push_back(8'h06);
    wait_idle(50);
    send_byte(8'h41);
    exp_q.push_back(8'h3F);
    wait_idle(50);
    check("unk_key_kept", aes_key, KEY2);

    // Plaintext with a long transmitter stall, then a back-to-back 'P' on the same key
    n0 = log_q.size();
    send_byte(8'h50);
    check("p_clears_done", {127'b0, io_done}, 128'd0);
    send_data(PT2, 0, 16);
    model_pt = PT2;
    core_respond(2);
    repeat (3) @(posedge io_clk);
    #1;
    tx_ready = 1'b0;
    repeat (50) @(posedge io_clk);
    #1;
    tx_ready = 1'b1;
    wait_idle(100);
    check("stall_count", log_q.size() - n0, 128'd16);
    send_byte(8'h50);
    send_data(PT3, 0, 16);
    model_pt = PT3;
    core_respond(1);
    wait_idle(100);
    check("b2b_key", aes_key, KEY2);

    // Core never answers: timeout reply
    send_byte(8'h50);
    send_data(FIPS_PT, 0, 16);
    model_pt = FIPS_PT;
    cyc_start = cyc;
    exp_q.push_back(8'h45);
    seen = 1'b0;
    for (int k = 0; k < TO + 20 && !seen; k++) begin
      @(posedge io_clk);
      #1;
      if (tx_valid) begin
        seen   = 1'b1;
        cyc_tx = cyc;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout_reply actual=none required=45");
    end else begin
      // Measured from the first cycle after the start pulse
      check("timeout_latency", cyc_tx - cyc_start - 1, TO);
    end
    wait_idle(20);
    check("timeout_byte", {120'b0, last_log()}, 128'h45);

    // Reset in the middle of a key frame, then a stray completion pulse
    send_byte(8'h4B);
    send_data(KEY3, 0, 7);
    do_reset();
    check("midrst_key", aes_key, 128'd0);
    check("midrst_rx_ready", {127'b0, rx_ready}, 128'd1);
    aes_done = 1'b1;
    aes_ct   = KEY3;
    @(posedge io_clk);
    #1;
    aes_done = 1'b0;
    aes_ct   = '0;
    repeat (5) @(posedge io_clk);
    #1;
    check("late_done_ignored", {127'b0, tx_valid}, 128'd0);
    send_byte(8'h50);
    send_data(PT2, 0, 16);
    model_pt = PT2;
    check("midrst_key_at_start", aes_key, 128'd0);
    core_respond(2);
    wait_idle(100);

    // Mask reseed command
    send_byte(8'h53);
`ifdef MASK_RESEED_EN
    send_data({32'hDEADBEEF, 96'h0}, 0, 4);
    exp_q.push_back(8'h06);
    wait_idle(50);
    check("seed_value", {96'b0, mask_seed}, 128'hDEADBEEF);
    check("seed_pulses", seed_pulses, 128'd1);
    check("seed_ack", {120'b0, last_log()}, 128'h06);
`else
    exp_q.push_back(8'h3F);
    wait_idle(50);
    check("seed_absent", {120'b0, last_log()}, 128'h3F);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
